// File: rtl/etapa6_signo_salida.sv
// etapa6_signo_salida: last stage of the pipelined divider. Applies sign correction
// to the unsigned quotient/remainder and buffers results in a 2-entry output queue.
`ifndef QLen
`define QLen 15
`endif
`ifndef DvLen
`define DvLen 7
`endif
`ifndef DdLen
`define DdLen 15
`endif

module etapa6_signo_salida (
    input  logic              clk,
    input  logic              reset,
    input  logic              goIn,
    input  logic [`DvLen:0]   divisorIn,
    input  logic [`DdLen:0]   dividendIn,
    input  logic [`QLen:0]    quotientIn,
    input  logic              negDivisorIn,
    input  logic              negDividendIn,
    input  logic              DivisorNoCeroIn,
    input  logic              ackIn,
    output logic              doneOut,
    output logic [`QLen:0]    quotientOut,
    output logic [`DvLen:0]   remainderOut,
    output logic              divZeroOut,
    output logic [1:0]        countOut,
    output logic              overflowOut
);
    localparam int QW = `QLen + 1;
    localparam int RW = `DvLen + 1;
    localparam int EW = QW + RW + 1;

    // Entry layout: {quotient, remainder, divZero}; truncating division, remainder follows dividend sign.
    function automatic logic [EW-1:0] correct_sign(
        input logic [QW-1:0] q_mag,
        input logic [RW-1:0] r_mag,
        input logic          neg_dv,
        input logic          neg_dd,
        input logic          dv_nz
    );
        logic [QW-1:0] q_v;
        logic [RW-1:0] r_v;
        if (!dv_nz) begin
            q_v = {QW{1'b1}};
            r_v = {RW{1'b0}};
        end else begin
            q_v = (neg_dv ^ neg_dd) ? ({QW{1'b0}} - q_mag) : q_mag;
            r_v = neg_dd ? ({RW{1'b0}} - r_mag) : r_mag;
        end
        return {q_v, r_v, ~dv_nz};
    endfunction

    logic [EW-1:0] entry_s;
    logic          pop_s;
    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          unused_s;

    assign unused_s = ^{divisorIn, dividendIn[`DdLen:RW]};
    assign entry_s  = correct_sign(quotientIn, dividendIn[RW-1:0],
                                   negDivisorIn, negDividendIn, DivisorNoCeroIn);
    assign pop_s    = ackIn & done_q;

    // Queue next-state: head always holds the oldest entry and is zero when empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (count_q)
            2'd0: begin
                if (goIn) begin
                    head_d  = entry_s;
                    count_d = 2'd1;
                end else begin
                    head_d  = {EW{1'b0}};
                end
            end
            2'd1: begin
                if (pop_s && goIn) begin
                    head_d = entry_s;
                end else if (pop_s) begin
                    head_d  = {EW{1'b0}};
                    count_d = 2'd0;
                end else if (goIn) begin
                    tail_d  = entry_s;
                    count_d = 2'd2;
                end else begin
                    head_d = head_q;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    tail_d  = goIn ? entry_s : {EW{1'b0}};
                    count_d = goIn ? 2'd2 : 2'd1;
                end else if (goIn) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            default: begin
                head_d  = {EW{1'b0}};
                tail_d  = {EW{1'b0}};
                count_d = 2'd0;
            end
        endcase
        done_d = (count_d != 2'd0);
    end

    // State registers with synchronous reset taking priority over push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {EW{1'b0}};
            tail_q  <= {EW{1'b0}};
            count_q <= 2'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign doneOut      = done_q;
    assign quotientOut  = head_q[EW-1 -: QW];
    assign remainderOut = head_q[RW:1];
    assign divZeroOut   = head_q[0];
    assign countOut     = count_q;
    assign overflowOut  = ovf_q;

endmodule

// File: tb/tb_etapa6_signo_salida.sv
// Bench for etapa6_signo_salida: signed-integer division reference model with a
// FIFO scoreboard, directed literal checks and a randomized phase.
`ifndef QLen
`define QLen 15
`endif
`ifndef DvLen
`define DvLen 7
`endif
`ifndef DdLen
`define DdLen 15
`endif

module tb_etapa6_signo_salida;
    localparam int QW = `QLen + 1;
    localparam int RW = `DvLen + 1;
    localparam int DW = `DdLen + 1;

    typedef struct packed {
        logic [QW-1:0] q;
        logic [RW-1:0] r;
        logic          dz;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          goIn;
    logic [RW-1:0] divisorIn;
    logic [DW-1:0] dividendIn;
    logic [QW-1:0] quotientIn;
    logic          negDivisorIn;
    logic          negDividendIn;
    logic          DivisorNoCeroIn;
    logic          ackIn;
    logic          doneOut;
    logic [QW-1:0] quotientOut;
    logic [RW-1:0] remainderOut;
    logic          divZeroOut;
    logic [1:0]    countOut;
    logic          overflowOut;

    int   n_checks = 0;
    int   n_fail = 0;
    ent_t exp_in;
    ent_t mq[$];
    logic m_ovf = 1'b0;
    logic m_valid = 1'b0;

    etapa6_signo_salida dut (
        .clk(clk), .reset(reset), .goIn(goIn), .divisorIn(divisorIn),
        .dividendIn(dividendIn), .quotientIn(quotientIn),
        .negDivisorIn(negDivisorIn), .negDividendIn(negDividendIn),
        .DivisorNoCeroIn(DivisorNoCeroIn), .ackIn(ackIn), .doneOut(doneOut),
        .quotientOut(quotientOut), .remainderOut(remainderOut),
        .divZeroOut(divZeroOut), .countOut(countOut), .overflowOut(overflowOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present the stage-5 view of dd/dv and record the signed result it must produce.
    task automatic set_op(input int dd, input int dv);
        int qv;
        int rv;
        dividendIn      = DW'($urandom);
        divisorIn       = RW'(dv < 0 ? -dv : dv);
        negDividendIn   = (dd < 0);
        DivisorNoCeroIn = (dv != 0);
        if (dv == 0) begin
            quotientIn   = QW'($urandom);
            negDivisorIn = 1'($urandom);
            exp_in.q     = {QW{1'b1}};
            exp_in.r     = {RW{1'b0}};
            exp_in.dz    = 1'b1;
        end else begin
            qv = dd / dv;
            rv = dd % dv;
            quotientIn               = QW'(qv < 0 ? -qv : qv);
            dividendIn[RW-1:0]       = RW'(rv < 0 ? -rv : rv);
            negDivisorIn             = (dv < 0);
            exp_in.q                 = QW'(qv);
            exp_in.r                 = RW'(rv);
            exp_in.dz                = 1'b0;
        end
    endtask

    // Reference model: FIFO of expected results updated at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                if (ackIn && mq.size() > 0) void'(mq.pop_front());
                if (goIn) begin
                    if (mq.size() == 2) m_ovf = 1'b1;
                    else mq.push_back(exp_in);
                end
            end
        end
    end

    // Compare process: every falling edge, outputs must match the model head.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e = (mq.size() > 0) ? mq[0] : ent_t'(0);
                check("done",     32'(doneOut),      32'(mq.size() > 0));
                check("count",    32'(countOut),     32'(mq.size()));
                check("overflow", 32'(overflowOut),  32'(m_ovf));
                check("quotient", 32'(quotientOut),  32'(e.q));
                check("remainder",32'(remainderOut), 32'(e.r));
                check("divzero",  32'(divZeroOut),   32'(e.dz));
            end
        end
    end

    initial begin
        int dd;
        int dv;
        reset = 1'b1; goIn = 1'b1; ackIn = 1'b0;
        set_op(-100, 7);
        @(negedge clk); @(negedge clk);
        check("rst_done", 32'(doneOut), 32'd0);
        check("rst_count", 32'(countOut), 32'd0);
        check("rst_ovf", 32'(overflowOut), 32'd0);
        check("rst_quo", 32'(quotientOut), 32'd0);
        reset = 1'b0; set_op(-100, 7);
        @(negedge clk);
        check("m100_7_done", 32'(doneOut), 32'd1);
        check("m100_7_quo", 32'(quotientOut), 32'h0000_FFF2);
        check("m100_7_rem", 32'(remainderOut), 32'h0000_00FE);
        check("m100_7_dz", 32'(divZeroOut), 32'd0);
        goIn = 1'b0; ackIn = 1'b1;
        @(negedge clk);
        check("pop_empty", 32'(countOut), 32'd0);
        ackIn = 1'b0; goIn = 1'b1; set_op(100, -7);
        @(negedge clk);
        set_op(-100, -7);
        @(negedge clk);
        goIn = 1'b0;
        check("b2b_count", 32'(countOut), 32'd2);
        check("b2b_quo0", 32'(quotientOut), 32'h0000_FFF2);
        check("b2b_rem0", 32'(remainderOut), 32'h0000_0002);
        ackIn = 1'b1;
        @(negedge clk);
        check("b2b_quo1", 32'(quotientOut), 32'h0000_000E);
        check("b2b_rem1", 32'(remainderOut), 32'h0000_00FE);
        check("b2b_count1", 32'(countOut), 32'd1);
        @(negedge clk);
        ackIn = 1'b0; goIn = 1'b1; set_op(-100, 0);
        @(negedge clk);
        goIn = 1'b0;
        check("dz_quo", 32'(quotientOut), 32'h0000_FFFF);
        check("dz_rem", 32'(remainderOut), 32'd0);
        check("dz_flag", 32'(divZeroOut), 32'd1);
        ackIn = 1'b1;
        @(negedge clk);
        ackIn = 1'b0; goIn = 1'b1; set_op(-100, 7);
        @(negedge clk);
        set_op(-100, -7);
        @(negedge clk);
        check("ovf_before", 32'(overflowOut), 32'd0);
        set_op(55, 3);
        @(negedge clk);
        check("ovf_set", 32'(overflowOut), 32'd1);
        check("ovf_count", 32'(countOut), 32'd2);
        check("ovf_head", 32'(quotientOut), 32'h0000_FFF2);
        set_op(100, -7); ackIn = 1'b1;
        @(negedge clk);
        check("ovf_sticky", 32'(overflowOut), 32'd1);
        check("ovf_count2", 32'(countOut), 32'd2);
        check("ovf_head2", 32'(quotientOut), 32'h0000_000E);
        reset = 1'b1; goIn = 1'b1; ackIn = 1'b1;
        @(negedge clk);
        check("midrst_count", 32'(countOut), 32'd0);
        check("midrst_done", 32'(doneOut), 32'd0);
        check("midrst_ovf", 32'(overflowOut), 32'd0);
        reset = 1'b0; goIn = 1'b0; ackIn = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            goIn  = ($urandom_range(0, 3) != 0);
            ackIn = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 32767));
            if ($urandom_range(0, 1) == 1) dd = -dd;
            dv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 127));
            if ($urandom_range(0, 1) == 1) dv = -dv;
            set_op(dd, dv);
        end

        @(negedge clk);
        reset = 1'b1; goIn = 1'b0; ackIn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            goIn = 1'b1; ackIn = 1'b1;
            dd = int'($urandom_range(0, 32767));
            dv = int'($urandom_range(1, 127));
            set_op(-dd, dv);
            @(negedge clk);
        end
        check("sustained_no_ovf", 32'(overflowOut), 32'd0);
        goIn = 1'b0; ackIn = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/etapa6_signo_salida.md
# etapa6_signo_salida

Final stage of the pipelined divider, directly downstream of iterative stages 3–5. It consumes the unsigned quotient/remainder magnitudes and the sign and zero-divisor flags, and applies sign correction in a registered step. Results are buffered in a 2-entry output queue with a done/ack handshake, so the non-stallable pipeline can hand results to a slower consumer. Queue overrun is flagged with a sticky error.

## Interface
- Parameters: none. Widths come from the global defines `QLen`, `DvLen` and `DdLen` (most-significant bit index). Queue depth is fixed at 2.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- goIn  input  1  a valid result from stage 5 is present this cycle
- divisorIn  input  `DvLen`+1  divisor magnitude; carried only, not output
- dividendIn  input  `DdLen`+1  partial-remainder register; bits [`DvLen`:0] hold the remainder magnitude, upper bits are ignored
- quotientIn  input  `QLen`+1  unsigned quotient magnitude
- negDivisorIn  input  1  original divisor was negative
- negDividendIn  input  1  original dividend was negative
- DivisorNoCeroIn  input  1  1 = divisor non-zero
- ackIn  input  1  consumer accepts the head result this cycle
- doneOut  output  1  head result valid (queue not empty)
- quotientOut  output  `QLen`+1  signed (two's-complement) quotient at the head
- remainderOut  output  `DvLen`+1  signed remainder at the head
- divZeroOut  output  1  head result came from a zero divisor
- countOut  output  2  queue occupancy, 0..2
- overflowOut  output  1  sticky: a result was dropped

## Operation
- **Sign rules.** Division truncates toward zero.
  - Quotient is negative when negDivisorIn XOR negDividendIn; the value is then the two's-complement negation of quotientIn, modulo 2^(`QLen`+1).
  - Remainder takes the sign of the dividend; when negDividendIn=1 the value is the negation of dividendIn[`DvLen`:0].
  - A zero magnitude stays 0 after negation.
- **Zero divisor.** When DivisorNoCeroIn=0: quotient = all ones, remainder = 0, divZero = 1. Sign flags are ignored.
- **Push.** When goIn=1, the corrected entry {quotient, remainder, divZero} is written at the queue tail.
- **Pop.** When ackIn=1 and doneOut=1, the head is removed. ackIn while doneOut=0 is ignored.
- **Queue behaviour.**
  - Queue is FIFO; results are never reordered.
  - Outputs always show the head entry. When doneOut=0, the data outputs are 0.
- **Simultaneous push and pop.**
  - Count is unchanged.
  - When count=1, the new entry becomes the head on the next cycle.
  - When count=2, the pop frees the slot and the push is accepted, so no overflow occurs.
- **Overflow.** goIn=1 while count=2 and no pop: the incoming result is dropped, the queue is unchanged, and overflowOut is set. It stays set until reset.
- **Reset.** All outputs are 0 and the queue is empty. reset takes priority over goIn and ackIn in the same cycle; any in-flight or queued result is discarded.

## Timing
- Latency: goIn at edge N into an empty queue gives doneOut=1 with correct data at edge N+1 (one register; sign correction is combinational before the queue).
- doneOut, countOut and all data outputs are registered; there is no combinational path from ackIn or goIn to any output.
- Throughput: one push per cycle. Sustained goIn with ackIn held at 1 never overflows.
- After an ack at edge M, the next entry (if any) appears on the outputs after edge M.
- overflowOut asserts at the edge following the dropped goIn.

## Test plan
Values assume `QLen`=15, `DvLen`=7, `DdLen`=15.
- Reset: hold reset 2 cycles with goIn=1 -> doneOut=0, countOut=0, overflowOut=0, all data 0.
- −100/7: quotientIn=14, dividendIn[7:0]=2, negDividendIn=1, negDivisorIn=0, DivisorNoCeroIn=1 -> next cycle doneOut=1, quotientOut=16'hFFF2, remainderOut=8'hFE, divZeroOut=0.
- 100/−7 then −100/−7, pushed back-to-back, no ack -> countOut=2; head quotient 16'hFFF2 / remainder 8'h02; after one ack, quotient 16'h000E / remainder 8'hFE.
- Zero divisor: DivisorNoCeroIn=0, quotientIn=5, negDividendIn=1 -> quotientOut=16'hFFFF, remainderOut=0, divZeroOut=1.
- Overflow: three consecutive goIn, no ack -> countOut=2, overflowOut=1 from the third edge on; the first two results are intact in order. A 4th goIn in the same cycle as an ack -> accepted, count stays 2, overflowOut stays 1.
- Reset mid-operation: count=2, then assert reset with ackIn=1 and goIn=1 -> next cycle count=0, doneOut=0, overflowOut=0.
